axi4_lite_master: RTL and testbench



---
 rtl/axi_lite_defs.sv | 21 ++
 rtl/axi4_lite_master.sv | 208 ++++++++++++++++++++
 tb/tb_axi4_lite_master.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_defs.sv
// Shared AXI4-Lite definitions: response codes, default protection and the
// initiator FSM state encoding.
package axi_lite_defs;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_EXOKAY  = 2'b01;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_DECERR  = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one valid/ready command in, one
// AXI4-Lite read or write out, one valid/ready response back.
module axi4_lite_master
  import axi_lite_defs::*;
#(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int WRITE_STROBE = DATA_SIZE / 8
) (
  input  logic                    m_axi_lite_clk,
  input  logic                    m_axi_lite_reset,

  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDRESS_SIZE-1:0] cmd_addr,
  input  logic [DATA_SIZE-1:0]    cmd_wdata,
  input  logic [WRITE_STROBE-1:0] cmd_wstrb,

  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_SIZE-1:0]    rsp_rdata,
  output logic [1:0]              rsp_resp,

  output logic [ADDRESS_SIZE-1:0] m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [2:0]              m_axi_awprot,

  output logic [DATA_SIZE-1:0]    m_axi_wdata,
  output logic [WRITE_STROBE-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,

  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,

  output logic [ADDRESS_SIZE-1:0] m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  output logic [2:0]              m_axi_arprot,

  input  logic [DATA_SIZE-1:0]    m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  state_t                  state_r;
  logic                    cmd_ready_r;
  logic [ADDRESS_SIZE-1:0] awaddr_r;
  logic                    awvalid_r;
  logic [DATA_SIZE-1:0]    wdata_r;
  logic [WRITE_STROBE-1:0] wstrb_r;
  logic                    wvalid_r;
  logic                    bready_r;
  logic [ADDRESS_SIZE-1:0] araddr_r;
  logic                    arvalid_r;
  logic                    rready_r;
  logic                    rsp_valid_r;
  logic                    rsp_write_r;
  logic [DATA_SIZE-1:0]    rsp_rdata_r;
  logic [1:0]              rsp_resp_r;
  logic                    aw_done_r;
  logic                    w_done_r;

  logic                    aw_hs_s;
  logic                    w_hs_s;
  logic                    aw_ok_s;
  logic                    w_ok_s;

  // A channel counts as finished if it completed earlier or is completing now.
  assign aw_hs_s = awvalid_r & m_axi_awready;
  assign w_hs_s  = wvalid_r & m_axi_wready;
  assign aw_ok_s = aw_done_r | aw_hs_s;
  assign w_ok_s  = w_done_r | w_hs_s;

  // Transaction FSM; every output below is a register written only here.
  always_ff @(posedge m_axi_lite_clk) begin
    if (m_axi_lite_reset) begin
      state_r     <= IDLE;
      cmd_ready_r <= 1'b0;
      awaddr_r    <= '0;
      awvalid_r   <= 1'b0;
      wdata_r     <= '0;
      wstrb_r     <= '0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      araddr_r    <= '0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_write_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_resp_r  <= 2'b00;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            cmd_ready_r <= 1'b0;
            if (cmd_write) begin
              awaddr_r  <= cmd_addr;
              wdata_r   <= cmd_wdata;
              wstrb_r   <= cmd_wstrb;
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              aw_done_r <= 1'b0;
              w_done_r  <= 1'b0;
              state_r   <= WR_REQ;
            end else begin
              araddr_r  <= cmd_addr;
              arvalid_r <= 1'b1;
              state_r   <= RD_REQ;
            end
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end
        WR_REQ: begin
          if (aw_hs_s) begin
            awvalid_r <= 1'b0;
            aw_done_r <= 1'b1;
          end
          if (w_hs_s) begin
            wvalid_r <= 1'b0;
            w_done_r <= 1'b1;
          end
          // bready only rises once both address and data have been accepted.
          if (aw_ok_s && w_ok_s) begin
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            bready_r  <= 1'b1;
            state_r   <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            bready_r    <= 1'b0;
            rsp_resp_r  <= m_axi_bresp;
            rsp_rdata_r <= '0;
            rsp_write_r <= 1'b1;
            rsp_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        RD_REQ: begin
          if (m_axi_arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (m_axi_rvalid) begin
            rready_r    <= 1'b0;
            rsp_resp_r  <= m_axi_rresp;
            rsp_rdata_r <= m_axi_rdata;
            rsp_write_r <= 1'b0;
            rsp_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          // Unreachable encodings fall back to a quiet idle.
          awvalid_r   <= 1'b0;
          wvalid_r    <= 1'b0;
          bready_r    <= 1'b0;
          arvalid_r   <= 1'b0;
          rready_r    <= 1'b0;
          rsp_valid_r <= 1'b0;
          cmd_ready_r <= 1'b0;
          aw_done_r   <= 1'b0;
          w_done_r    <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_write     = rsp_write_r;
  assign rsp_rdata     = rsp_rdata_r;
  assign rsp_resp      = rsp_resp_r;
  assign m_axi_awaddr  = awaddr_r;
  assign m_axi_awvalid = awvalid_r;
  assign m_axi_awprot  = PROT_DEFAULT;
  assign m_axi_wdata   = wdata_r;
  assign m_axi_wstrb   = wstrb_r;
  assign m_axi_wvalid  = wvalid_r;
  assign m_axi_bready  = bready_r;
  assign m_axi_araddr  = araddr_r;
  assign m_axi_arvalid = arvalid_r;
  assign m_axi_arprot  = PROT_DEFAULT;
  assign m_axi_rready  = rready_r;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Self-checking bench for axi4_lite_master: a configurable subordinate model,
// a response scoreboard and one task per scenario.
module tb_axi4_lite_master;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [2:0]  awprot;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [2:0]  arprot;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // subordinate model configuration
  int          aw_delay  = 0;
  int          w_delay   = 0;
  int          ar_delay  = 0;
  int          b_delay   = 0;
  int          r_delay   = 0;
  logic [1:0]  cfg_bresp = 2'b00;
  logic [1:0]  cfg_rresp = 2'b00;
  logic [31:0] rd_value  = 32'h0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;

  // scoreboard entry: {rsp_write, rsp_rdata, rsp_resp}
  logic [34:0] exp_q[$];

  axi4_lite_master #(
    .ADDRESS_SIZE(32),
    .DATA_SIZE   (32),
    .WRITE_STROBE(4)
  ) dut (
    .m_axi_lite_clk  (clk),
    .m_axi_lite_reset(reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .cmd_wstrb       (cmd_wstrb),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_write       (rsp_write),
    .rsp_rdata       (rsp_rdata),
    .rsp_resp        (rsp_resp),
    .m_axi_awaddr    (awaddr),
    .m_axi_awvalid   (awvalid),
    .m_axi_awready   (awready),
    .m_axi_awprot    (awprot),
    .m_axi_wdata     (wdata),
    .m_axi_wstrb     (wstrb),
    .m_axi_wvalid    (wvalid),
    .m_axi_wready    (wready),
    .m_axi_bresp     (bresp),
    .m_axi_bvalid    (bvalid),
    .m_axi_bready    (bready),
    .m_axi_araddr    (araddr),
    .m_axi_arvalid   (arvalid),
    .m_axi_arready   (arready),
    .m_axi_arprot    (arprot),
    .m_axi_rdata     (rdata),
    .m_axi_rresp     (rresp),
    .m_axi_rvalid    (rvalid),
    .m_axi_rready    (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Subordinate model: decides ready/valid for the coming edge from the
  // master's current outputs, with a per-channel cycle delay.
  always @(negedge clk) begin
    if (awvalid) begin awready = (aw_cnt >= aw_delay); aw_cnt++; end
    else begin awready = 1'b0; aw_cnt = 0; end
    if (wvalid) begin wready = (w_cnt >= w_delay); w_cnt++; end
    else begin wready = 1'b0; w_cnt = 0; end
    if (arvalid) begin arready = (ar_cnt >= ar_delay); ar_cnt++; end
    else begin arready = 1'b0; ar_cnt = 0; end
    if (bready) begin bvalid = (b_cnt >= b_delay); bresp = cfg_bresp; b_cnt++; end
    else begin bvalid = 1'b0; bresp = 2'b00; b_cnt = 0; end
    if (rready) begin
      rvalid = (r_cnt >= r_delay); rdata = rd_value; rresp = cfg_rresp; r_cnt++;
    end else begin
      rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; r_cnt = 0;
    end
  end

  // Scoreboard: compare every accepted response against the oldest expectation.
  always @(negedge clk) begin
    logic [34:0] e;
    #1;
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_rsp got=%h exp=none", {rsp_write, rsp_rdata, rsp_resp});
      end else begin
        e = exp_q.pop_front();
        if ({rsp_write, rsp_rdata, rsp_resp} !== e) begin
          failures++;
          $display("FAIL sb_rsp got=%h exp=%h", {rsp_write, rsp_rdata, rsp_resp}, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Drives one command starting at a negedge; returns at the negedge of the
  // cycle after the handshake with n = handshake cycle (-1 on timeout).
  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] er, input logic [1:0] eresp,
                          output int n);
    int t = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (cmd_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    checks++;
    if (t >= 100) begin
      failures++;
      $display("FAIL cmd_accept got=timeout exp=cmd_ready");
      cmd_valid = 1'b0;
      n = -1;
    end else begin
      n = cyc;
      exp_q.push_back({w, er, eresp});
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin
      failures++;
      $display("FAIL reset_valids got=%b exp=000000", {awvalid, wvalid, arvalid, bready, rready, rsp_valid});
    end
    checks++;
    if ({awaddr, wdata, wstrb, araddr, awprot, arprot} !== 106'h0) begin
      failures++; $display("FAIL reset_axi_payload got=%h/%h/%h/%h exp=0", awaddr, wdata, wstrb, araddr);
    end
    checks++;
    if ({rsp_write, rsp_rdata, rsp_resp} !== 35'h0) begin
      failures++; $display("FAIL reset_rsp_payload got=%h exp=0", {rsp_write, rsp_rdata, rsp_resp});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL post_reset_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_write_basic();
    int n;
    send_cmd(1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00, n);
    checks++;
    if ({awvalid, wvalid, cmd_ready} !== 3'b110) begin
      failures++; $display("FAIL wr_n1_valids got=%b exp=110", {awvalid, wvalid, cmd_ready});
    end
    checks++;
    if (awaddr !== 32'h0 || wdata !== 32'hDEAD_BEEF || wstrb !== 4'hF) begin
      failures++; $display("FAIL wr_n1_payload got=%h/%h/%h exp=0/deadbeef/f", awaddr, wdata, wstrb);
    end
    @(negedge clk);
    checks++;
    if ({bready, awvalid, wvalid, rsp_valid} !== 4'b1000) begin
      failures++; $display("FAIL wr_n2_bready got=%b exp=1000", {bready, awvalid, wvalid, rsp_valid});
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, bready, cmd_ready} !== 3'b100) begin
      failures++; $display("FAIL wr_n3_rsp_valid got=%b exp=100", {rsp_valid, bready, cmd_ready});
    end
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      failures++; $display("FAIL wr_n4_cmd_ready got=%b exp=10", {cmd_ready, rsp_valid});
    end
  endtask

  task automatic test_write_orders();
    int awd[3] = '{3, 0, 2};
    int wd[3]  = '{0, 3, 2};
    for (int i = 0; i < 3; i++) begin
      int n, t, aw_cyc, w_cyc;
      logic stable, bad_b;
      logic [31:0] addr, data;
      aw_delay = awd[i]; w_delay = wd[i];
      addr = 32'h100 + 32'(i * 16);
      data = $urandom;
      send_cmd(1'b1, addr, data, 4'h5, 32'h0, 2'b00, n);
      aw_cyc = 0; w_cyc = 0; stable = 1'b1; bad_b = 1'b0; t = 0;
      while (rsp_valid !== 1'b1 && t < 60) begin
        if (awvalid) begin aw_cyc++; if (awaddr !== addr) stable = 1'b0; end
        if (wvalid) begin w_cyc++; if (wdata !== data || wstrb !== 4'h5) stable = 1'b0; end
        if (bready && (awvalid || wvalid)) bad_b = 1'b1;
        @(negedge clk); t++;
      end
      checks++;
      if (rsp_valid !== 1'b1) begin failures++; $display("FAIL wr_order%0d_rsp got=timeout exp=rsp_valid", i); end
      checks++;
      if (aw_cyc != awd[i] + 1) begin failures++; $display("FAIL wr_order%0d_awvalid_cycles got=%0d exp=%0d", i, aw_cyc, awd[i] + 1); end
      checks++;
      if (w_cyc != wd[i] + 1) begin failures++; $display("FAIL wr_order%0d_wvalid_cycles got=%0d exp=%0d", i, w_cyc, wd[i] + 1); end
      checks++;
      if (stable !== 1'b1) begin failures++; $display("FAIL wr_order%0d_payload_stable got=%b exp=1", i, stable); end
      checks++;
      if (bad_b !== 1'b0) begin failures++; $display("FAIL wr_order%0d_early_bready got=%b exp=0", i, bad_b); end
      @(negedge clk);
    end
    aw_delay = 0; w_delay = 0;
  endtask

  task automatic test_read_slow();
    int n, t, r_cyc;
    r_delay = 5; rd_value = 32'h1234_5678; cfg_rresp = 2'b00;
    send_cmd(1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF, 32'h1234_5678, 2'b00, n);
    checks++;
    if ({arvalid, rready, awvalid, wvalid} !== 4'b1000 || araddr !== 32'h4) begin
      failures++; $display("FAIL rd_n1_arvalid got=%b/%h exp=1000/00000004", {arvalid, rready, awvalid, wvalid}, araddr);
    end
    r_cyc = 0; t = 0;
    while (rsp_valid !== 1'b1 && t < 40) begin
      if (rready) r_cyc++;
      @(negedge clk); t++;
    end
    checks++;
    if (r_cyc != 6) begin failures++; $display("FAIL rd_rready_cycles got=%0d exp=6", r_cyc); end
    checks++;
    if ({rsp_valid, rready} !== 2'b10) begin failures++; $display("FAIL rd_rsp_valid got=%b exp=10", {rsp_valid, rready}); end
    @(negedge clk);
    r_delay = 0;
  endtask

  task automatic test_read_error();
    int n, t, ar_extra;
    cfg_rresp = 2'b10; rd_value = 32'hA5A5_0F0F;
    send_cmd(1'b0, 32'h0000_0008, 32'h0, 4'h0, 32'hA5A5_0F0F, 2'b10, n);
    ar_extra = 0; t = 0;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && t < 40) begin
      if (arvalid) ar_extra++;
      @(negedge clk); t++;
    end
    repeat (3) begin
      if (arvalid) ar_extra++;
      @(negedge clk);
    end
    checks++;
    if (ar_extra != 0) begin failures++; $display("FAIL rd_err_retry got=%0d exp=0", ar_extra); end
    cfg_rresp = 2'b00; rd_value = 32'h0BAD_F00D;
    send_cmd(1'b0, 32'h0000_000C, 32'h0, 4'h0, 32'h0BAD_F00D, 2'b00, n);
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin @(negedge clk); t++; end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rd_after_err got=%0d pending exp=0", exp_q.size()); end
  endtask

  task automatic test_rsp_stall();
    int n, t;
    logic stable;
    logic [34:0] snap;
    rsp_ready = 1'b0; cfg_bresp = 2'b11;
    send_cmd(1'b1, 32'h0000_0020, 32'hCAFE_0001, 4'h3, 32'h0, 2'b11, n);
    t = 0;
    while (rsp_valid !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    snap = {rsp_write, rsp_rdata, rsp_resp};
    checks++;
    if (snap !== {1'b1, 32'h0, 2'b11}) begin failures++; $display("FAIL stall_payload got=%h exp=%h", snap, {1'b1, 32'h0, 2'b11}); end
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || {rsp_write, rsp_rdata, rsp_resp} !== snap || cmd_ready !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin failures++; $display("FAIL stall_stable got=%b exp=1", stable); end
    rsp_ready = 1'b1; cfg_bresp = 2'b00;
    @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin failures++; $display("FAIL stall_release got=%b exp=01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_back_to_back();
    int n, t;
    cfg_bresp = 2'b01; rd_value = 32'h600D_CAFE;
    send_cmd(1'b1, 32'h0000_0030, 32'h1122_3344, 4'hF, 32'h0, 2'b01, n);
    send_cmd(1'b0, 32'h0000_0030, 32'h0, 4'h0, 32'h600D_CAFE, 2'b00, n);
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_drain got=%0d pending exp=0", exp_q.size()); end
    cfg_bresp = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    logic saw_rsp;
    aw_delay = 20;
    send_cmd(1'b1, 32'h0000_0040, 32'h5555_AAAA, 4'hF, 32'h0, 2'b00, n);
    checks++;
    if ({awvalid, awready} !== 2'b10) begin failures++; $display("FAIL rst_mid_setup got=%b exp=10", {awvalid, awready}); end
    if (n >= 0) void'(exp_q.pop_back());
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready} !== 7'b0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%b exp=0000000", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready});
    end
    reset = 1'b0; aw_delay = 0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_cmd_ready got=%b exp=1", cmd_ready); end
    saw_rsp = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid !== 1'b0 || awvalid !== 1'b0) saw_rsp = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_rsp !== 1'b0) begin failures++; $display("FAIL rst_mid_no_rsp got=%b exp=0", saw_rsp); end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
    cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b1;
    awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    test_reset();
    test_write_basic();
    test_write_orders();
    test_read_slow();
    test_read_error();
    test_rsp_stall();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL final_queue got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
